mem_req_arbiter: RTL and testbench

- Merges REQUESTERS independent read/write request channels onto the single memory port of the unit under test.
- Sits directly upstream of the memory and downstream of the per-requester traffic generators.
- Read and write channels are arbitrated independently, each round-robin.
- Read data returns from memory strictly in order and is routed back to the originating requester through an outstanding-tag FIFO.

---
 rtl/transaction_pkg.sv | 9 +
 rtl/mem_req_arbiter_rr_arbiter.sv | 41 ++++
 rtl/mem_req_arbiter.sv | 120 ++++++++++++
 tb/tb_mem_req_arbiter.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/transaction_pkg.sv
// rtl/transaction_pkg.sv - shared transaction parameters and tag type
package transaction_pkg;
    localparam int REQUESTERS  = 3;
    localparam int DATA_WIDTH  = 16;
    localparam int ADDR_WIDTH  = 16;
    localparam int OUTSTANDING = 4;

    typedef logic [$clog2(REQUESTERS)-1:0] tag_t;
endpackage

// File: rtl/mem_req_arbiter_rr_arbiter.sv
// rtl/mem_req_arbiter_rr_arbiter.sv - round-robin grant, pointer advances past winner on handshake
module rr_arbiter #(
    parameter int N  = 3,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          reset_p,
    input  logic [N-1:0]  req,
    input  logic          advance,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx
);
    logic [IW-1:0] ptr;
    logic          found;
    int            idx;

    // Search starts at ptr; the first active requester wins.
    always_comb begin
        grant     = '0;
        grant_idx = ptr;
        found     = 1'b0;
        idx       = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N) idx = idx - N;
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = IW'(idx);
            end
        end
    end

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= (int'(grant_idx) == N - 1) ? '0 : grant_idx + IW'(1);
        end
    end
endmodule

// File: rtl/mem_req_arbiter.sv
// rtl/mem_req_arbiter.sv - merges requester read/write channels onto one memory port
// Optional per-requester handshake counters: MEM_REQ_ARBITER_STAT_EN
module mem_req_arbiter
    import transaction_pkg::*;
#(
    parameter int REQUESTERS  = transaction_pkg::REQUESTERS,
    parameter int DATA_WIDTH  = transaction_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH  = transaction_pkg::ADDR_WIDTH,
    parameter int OUTSTANDING = transaction_pkg::OUTSTANDING
) (
    input  logic                             clk,
    input  logic                             reset_p,
    input  logic [REQUESTERS*ADDR_WIDTH-1:0] up_r_addr,
    input  logic [REQUESTERS-1:0]            up_r_avalid,
    output logic [REQUESTERS-1:0]            up_r_aready,
    output logic [REQUESTERS-1:0]            up_r_dvalid,
    output logic [DATA_WIDTH-1:0]            up_r_data,
    input  logic [REQUESTERS*ADDR_WIDTH-1:0] up_w_addr,
    input  logic [REQUESTERS*DATA_WIDTH-1:0] up_w_data,
    input  logic [REQUESTERS-1:0]            up_w_valid,
    output logic [REQUESTERS-1:0]            up_w_ready,
    output logic [ADDR_WIDTH-1:0]            dn_r_addr,
    output logic                             dn_r_avalid,
    input  logic                             dn_r_aready,
    input  logic                             dn_r_dvalid,
    input  logic [DATA_WIDTH-1:0]            dn_r_data,
    output logic [ADDR_WIDTH-1:0]            dn_w_addr,
    output logic [DATA_WIDTH-1:0]            dn_w_data,
    output logic                             dn_w_valid,
    input  logic                             dn_w_ready,
    output logic                             proto_err
`ifdef MEM_REQ_ARBITER_STAT_EN
    ,
    output logic [REQUESTERS*32-1:0]         stat_rd_cnt,
    output logic [REQUESTERS*32-1:0]         stat_wr_cnt
`endif
);
    localparam int IW = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;
    localparam int PW = $clog2(OUTSTANDING);

    logic [REQUESTERS-1:0] rd_grant, wr_grant;
    logic [IW-1:0]         rd_idx, wr_idx;
    logic                  rd_hs, wr_hs, pop, tag_full, tag_empty;
    logic [PW-1:0]         wr_p, rd_p;
    logic [PW:0]           cnt;
    tag_t                  tag_mem [OUTSTANDING];

    assign tag_full  = (cnt == (PW+1)'(OUTSTANDING));
    assign tag_empty = (cnt == '0);

    assign dn_r_avalid = (|up_r_avalid) && !tag_full;
    assign dn_r_addr   = up_r_addr[int'(rd_idx)*ADDR_WIDTH +: ADDR_WIDTH];
    assign up_r_aready = rd_grant & {REQUESTERS{dn_r_aready && !tag_full}};
    assign rd_hs       = dn_r_avalid && dn_r_aready;

    assign dn_w_valid  = |up_w_valid;
    assign dn_w_addr   = up_w_addr[int'(wr_idx)*ADDR_WIDTH +: ADDR_WIDTH];
    assign dn_w_data   = up_w_data[int'(wr_idx)*DATA_WIDTH +: DATA_WIDTH];
    assign up_w_ready  = wr_grant & {REQUESTERS{dn_w_ready}};
    assign wr_hs       = dn_w_valid && dn_w_ready;

    assign pop = dn_r_dvalid && !tag_empty;

    rr_arbiter #(.N(REQUESTERS), .IW(IW)) u_rd_arb (
        .clk(clk), .reset_p(reset_p), .req(up_r_avalid), .advance(rd_hs),
        .grant(rd_grant), .grant_idx(rd_idx)
    );

    rr_arbiter #(.N(REQUESTERS), .IW(IW)) u_wr_arb (
        .clk(clk), .reset_p(reset_p), .req(up_w_valid), .advance(wr_hs),
        .grant(wr_grant), .grant_idx(wr_idx)
    );

    always_ff @(posedge clk) begin
        if (rd_hs) tag_mem[wr_p] <= tag_t'(rd_idx);
    end

    // Full is judged on the pre-pop count, so a same-cycle pop never frees a slot early.
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            wr_p        <= '0;
            rd_p        <= '0;
            cnt         <= '0;
            up_r_dvalid <= '0;
            up_r_data   <= '0;
            proto_err   <= 1'b0;
        end else begin
            if (rd_hs) wr_p <= wr_p + PW'(1);
            if (pop)   rd_p <= rd_p + PW'(1);
            case ({rd_hs, pop})
                2'b10:   cnt <= cnt + (PW+1)'(1);
                2'b01:   cnt <= cnt - (PW+1)'(1);
                default: cnt <= cnt;
            endcase
            if (pop) begin
                up_r_dvalid <= REQUESTERS'(1) << tag_mem[rd_p];
                up_r_data   <= dn_r_data;
            end else begin
                up_r_dvalid <= '0;
            end
            if (dn_r_dvalid && tag_empty) proto_err <= 1'b1;
        end
    end

`ifdef MEM_REQ_ARBITER_STAT_EN
    for (genvar i = 0; i < REQUESTERS; i++) begin : g_stat
        always_ff @(posedge clk or posedge reset_p) begin
            if (reset_p) begin
                stat_rd_cnt[i*32 +: 32] <= '0;
                stat_wr_cnt[i*32 +: 32] <= '0;
            end else begin
                if (up_r_aready[i] && stat_rd_cnt[i*32 +: 32] != '1)
                    stat_rd_cnt[i*32 +: 32] <= stat_rd_cnt[i*32 +: 32] + 32'd1;
                if (up_w_ready[i] && up_w_valid[i] && stat_wr_cnt[i*32 +: 32] != '1)
                    stat_wr_cnt[i*32 +: 32] <= stat_wr_cnt[i*32 +: 32] + 32'd1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_mem_req_arbiter.sv
// tb/tb_mem_req_arbiter.sv - randomized bench against a queue-based reference model
module tb_mem_req_arbiter;
    localparam int N   = 3;
    localparam int AW  = 16;
    localparam int DW  = 16;
    localparam int OUT = 4;

    logic            clk = 1'b0;
    logic            reset_p;
    logic [N*AW-1:0] up_r_addr, up_w_addr;
    logic [N*DW-1:0] up_w_data;
    logic [N-1:0]    up_r_avalid, up_r_aready, up_r_dvalid, up_w_valid, up_w_ready;
    logic [DW-1:0]   up_r_data, dn_r_data, dn_w_data;
    logic [AW-1:0]   dn_r_addr, dn_w_addr;
    logic            dn_r_avalid, dn_r_aready, dn_r_dvalid, dn_w_valid, dn_w_ready, proto_err;

    always #5 clk = ~clk;

    mem_req_arbiter dut (
        .clk(clk), .reset_p(reset_p),
        .up_r_addr(up_r_addr), .up_r_avalid(up_r_avalid), .up_r_aready(up_r_aready),
        .up_r_dvalid(up_r_dvalid), .up_r_data(up_r_data),
        .up_w_addr(up_w_addr), .up_w_data(up_w_data), .up_w_valid(up_w_valid),
        .up_w_ready(up_w_ready),
        .dn_r_addr(dn_r_addr), .dn_r_avalid(dn_r_avalid), .dn_r_aready(dn_r_aready),
        .dn_r_dvalid(dn_r_dvalid), .dn_r_data(dn_r_data),
        .dn_w_addr(dn_w_addr), .dn_w_data(dn_w_data), .dn_w_valid(dn_w_valid),
        .dn_w_ready(dn_w_ready), .proto_err(proto_err)
    );

    int checks = 0;
    int failures = 0;

    // stimulus state: each valid holds its payload until accepted
    logic [N-1:0]  r_val = '0, w_val = '0;
    logic [AW-1:0] r_addr [N];
    logic [AW-1:0] w_addr [N];
    logic [DW-1:0] w_data [N];

    // reference model
    int            m_rd_ptr, m_wr_ptr;
    int            m_tags [$];
    logic [N-1:0]  m_dvalid;
    logic [DW-1:0] m_data;
    logic          m_err;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int pick(input logic [N-1:0] v, input int ptr);
        for (int k = 0; k < N; k++)
            if (v[(ptr + k) % N]) return (ptr + k) % N;
        return -1;
    endfunction

    task automatic model_reset();
        m_rd_ptr = 0;
        m_wr_ptr = 0;
        m_tags.delete();
        m_dvalid = '0;
        m_data   = '0;
        m_err    = 1'b0;
    endtask

    task automatic pack();
        up_r_avalid = r_val;
        up_w_valid  = w_val;
        for (int i = 0; i < N; i++) begin
            up_r_addr[i*AW +: AW] = r_addr[i];
            up_w_addr[i*AW +: AW] = w_addr[i];
            up_w_data[i*DW +: DW] = w_data[i];
        end
    endtask

    task automatic check_registered();
        check_eq("up_r_dvalid", 32'(up_r_dvalid), 32'(m_dvalid));
        check_eq("up_r_data", 32'(up_r_data), 32'(m_data));
        check_eq("proto_err", 32'(proto_err), 32'(m_err));
    endtask

    task automatic run_cycles(input int n, input int dval_pct, input int req_pct, input bit spurious);
        int  gr, gw;
        bit  full, rhs, whs;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            check_registered();
            for (int i = 0; i < N; i++) begin
                if (!r_val[i] && $urandom_range(0, 99) < req_pct) begin
                    r_val[i]  = 1'b1;
                    r_addr[i] = AW'($urandom);
                end
                if (!w_val[i] && $urandom_range(0, 99) < req_pct) begin
                    w_val[i]  = 1'b1;
                    w_addr[i] = AW'($urandom);
                    w_data[i] = DW'($urandom);
                end
            end
            dn_r_aready = ($urandom_range(0, 99) < 70);
            dn_w_ready  = ($urandom_range(0, 99) < 70);
            if (m_tags.size() > 0) dn_r_dvalid = ($urandom_range(0, 99) < dval_pct);
            else                   dn_r_dvalid = spurious && ($urandom_range(0, 99) < 5);
            dn_r_data = DW'($urandom);
            pack();
            #1;
            gr   = pick(r_val, m_rd_ptr);
            gw   = pick(w_val, m_wr_ptr);
            full = (m_tags.size() == OUT);
            rhs  = (gr >= 0) && !full && dn_r_aready;
            whs  = (gw >= 0) && dn_w_ready;
            check_eq("dn_r_avalid", 32'(dn_r_avalid), 32'((gr >= 0) && !full));
            if (gr >= 0) check_eq("dn_r_addr", 32'(dn_r_addr), 32'(r_addr[gr]));
            check_eq("up_r_aready", 32'(up_r_aready), rhs ? (32'd1 << gr) : 32'd0);
            check_eq("dn_w_valid", 32'(dn_w_valid), 32'(gw >= 0));
            if (gw >= 0) begin
                check_eq("dn_w_addr", 32'(dn_w_addr), 32'(w_addr[gw]));
                check_eq("dn_w_data", 32'(dn_w_data), 32'(w_data[gw]));
            end
            check_eq("up_w_ready", 32'(up_w_ready), whs ? (32'd1 << gw) : 32'd0);
            // response side sees the queue as it was before this cycle's push
            m_dvalid = '0;
            if (dn_r_dvalid) begin
                if (m_tags.size() > 0) begin
                    m_dvalid = N'(1) << m_tags.pop_front();
                    m_data   = dn_r_data;
                end else begin
                    m_err = 1'b1;
                end
            end
            if (rhs) begin
                m_tags.push_back(gr);
                m_rd_ptr = (gr + 1) % N;
                r_val[gr] = 1'b0;
            end
            if (whs) begin
                m_wr_ptr = (gw + 1) % N;
                w_val[gw] = 1'b0;
            end
        end
    endtask

    initial begin
        reset_p     = 1'b1;
        dn_r_aready = 1'b0;
        dn_w_ready  = 1'b0;
        dn_r_dvalid = 1'b0;
        dn_r_data   = '0;
        for (int i = 0; i < N; i++) begin
            r_addr[i] = '0;
            w_addr[i] = '0;
            w_data[i] = '0;
        end
        pack();
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_up_r_dvalid", 32'(up_r_dvalid), 32'd0);
        check_eq("rst_up_r_data", 32'(up_r_data), 32'd0);
        check_eq("rst_proto_err", 32'(proto_err), 32'd0);
        check_eq("rst_dn_r_avalid", 32'(dn_r_avalid), 32'd0);
        check_eq("rst_dn_w_valid", 32'(dn_w_valid), 32'd0);
        reset_p = 1'b0;

        run_cycles(1500, 50, 50, 1'b0);
        run_cycles(400, 8, 80, 1'b0);   // slow memory: tag FIFO fills
        run_cycles(300, 60, 30, 1'b1);  // sparse traffic with stray read data

        // reset in the middle of a burst
        run_cycles(20, 5, 90, 1'b0);
        @(negedge clk);
        check_registered();
        #2;
        reset_p = 1'b1;
        #1;
        check_eq("mid_rst_up_r_dvalid", 32'(up_r_dvalid), 32'd0);
        check_eq("mid_rst_up_r_data", 32'(up_r_data), 32'd0);
        check_eq("mid_rst_proto_err", 32'(proto_err), 32'd0);
        check_eq("mid_rst_dn_r_avalid", 32'(dn_r_avalid), 32'(|r_val));
        model_reset();
        @(posedge clk);
        #2;
        reset_p = 1'b0;

        run_cycles(200, 40, 50, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
